bcd_display_mux: RTL and testbench

- Downstream consumer of the decade counter chain (mod_10_counter digits).
- Snapshots a vector of BCD digits and time-multiplexes them onto one 7-segment bus with one-hot digit enables.
- Provides a frame_done strobe so upstream logic can align updates to display frames.
- Sits between the counter datapath and the board-level display pins.

---
 rtl/bcd_display_mux.sv | 113 +++++++++++
 tb/tb_bcd_display_mux.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bcd_display_mux.sv
// Multiplexed 7-segment driver: snapshots NUM_DIGITS BCD digits and scans them one per REFRESH_DIV cycles.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module bcd_seg_lane (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h40;
    case (digit)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    if (blank) seg = 7'h00;
  end
endmodule

module bcd_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       bcd_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int CW  = $clog2(REFRESH_DIV);
  localparam bit INV = (ACTIVE_LOW != 0);

  logic [CW-1:0]                 cnt;
  logic [IW-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]    sh_digit;
  logic [NUM_DIGITS-1:0]         sh_dp;
  logic [NUM_DIGITS-1:0][6:0]    lane_seg;
  logic [NUM_DIGITS-1:0]         blank;
  logic                          wrap, last;

  assign wrap = (cnt == CW'(REFRESH_DIV - 1));
  assign last = (idx == IW'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (sh_digit[i] == 4'd0);
      blank[i]   = (i != 0) && zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    bcd_seg_lane u_lane (
      .digit (sh_digit[g]),
      .blank (blank[g]),
      .seg   (lane_seg[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      sh_digit   <= '0;
      sh_dp      <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        sh_digit <= bcd_in;
        sh_dp    <= dp_in;
      end
      cnt        <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= last ? '0 : idx + IW'(1);
      frame_done <= wrap & last;
    end
  end

  // Output stage samples the pre-edge index, so pins lag the scan index by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg       <= {7{INV}};
      dp        <= INV;
      an        <= {NUM_DIGITS{INV}};
      digit_idx <= '0;
    end else begin
      seg       <= lane_seg[idx] ^ {7{INV}};
      dp        <= sh_dp[idx] ^ INV;
      an        <= (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{INV}};
      digit_idx <= idx;
    end
  end
endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux (4 digits, 4-cycle slots, active-low); expected segment codes are hand-tabulated.
module tb_bcd_display_mux;
  logic        clk = 1'b0;
  logic        rst, load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  bcd_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] idx;
    logic       fd;
  } out_t;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dpv;
    logic [3:0][6:0] segs;  // [digit] active-low segment code
  } vec_t;

  out_t            sbq[$];
  int              n_cmp = 0, n_bad = 0;
  int              m_cnt = 0, m_idx = 0;
  logic [3:0][6:0] m_seg;
  logic [3:0]      m_dp;
  logic [3:0][6:0] rst_seg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick(input string tag, input logic r, input logic l, input logic [15:0] b,
                      input logic [3:0] d, input logic [3:0][6:0] es);
    out_t e, a;
    rst = r; load = l; bcd_in = b; dp_in = d;
    if (r) begin
      e = '{7'h7F, 1'b1, 4'hF, 2'd0, 1'b0};
      m_cnt = 0; m_idx = 0; m_seg = rst_seg; m_dp = '0;
    end else begin
      e.seg = m_seg[m_idx];
      e.dp  = ~m_dp[m_idx];
      e.an  = ~(4'(4'b0001 << m_idx));
      e.idx = 2'(m_idx);
      e.fd  = (m_cnt == 3) && (m_idx == 3);
      if (l) begin m_seg = es; m_dp = d; end
      if (m_cnt == 3) begin m_cnt = 0; m_idx = (m_idx + 1) % 4; end
      else m_cnt++;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    a = '{seg, dp, an, digit_idx, frame_done};
    e = sbq.pop_front();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got seg=%h dp=%b an=%h idx=%0d fd=%b, want seg=%h dp=%b an=%h idx=%0d fd=%b",
               tag, a.seg, a.dp, a.an, a.idx, a.fd, e.seg, e.dp, e.an, e.idx, e.fd);
    end
  endtask

  task automatic idle(input string tag, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick(tag, 1'b0, 1'b0, 16'h0, 4'h0, m_seg);
      if (frame_done) pulses++;
    end
  endtask

  vec_t vecs[5];

  initial begin
    int p, guard;
    logic [3:0][6:0] five;
    rst_seg = {LZ, LZ, LZ, 7'h40};
    m_seg = rst_seg; m_dp = '0;
    rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0;

    vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h00A9, 4'b0000, {LZ,    LZ,    7'h3F, 7'h10}};
    vecs[2] = '{16'h5678, 4'b0100, {7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[3] = '{16'h0000, 4'b0001, {LZ,    LZ,    LZ,    7'h40}};
    vecs[4] = '{16'h09F0, 4'b1010, {LZ,    7'h10, 7'h3F, 7'h40}};
    five    = {LZ, LZ, LZ, 7'h12};

    for (int i = 0; i < 3; i++) tick("reset_hold", 1'b1, 1'b0, 16'hFFFF, 4'hF, rst_seg);
    tick("release", 1'b0, 1'b0, 16'h0, 4'h0, rst_seg);
    check("release_an", 32'(an), 32'hE);
    check("release_seg", 32'(seg), 32'h40);
    idle("idle", 3, p);

    // One load per vector, then a whole frame: exactly one frame_done per 16 cycles.
    foreach (vecs[v]) begin
      tick("vec_load", 1'b0, 1'b1, vecs[v].bcd, vecs[v].dpv, vecs[v].segs);
      idle("vec_scan", 16, p);
      check("vec_frame_pulses", 32'(p), 32'd1);
    end

    // Load held high tracks bcd_in every cycle.
    for (int i = 0; i < 6; i++)
      tick("load_held", 1'b0, 1'b1, vecs[i % 5].bcd, vecs[i % 5].dpv, vecs[i % 5].segs);
    idle("held_scan", 16, p);

    // Mid-slot load while digit 0 is being scanned.
    guard = 0;
    while (!(m_idx == 0 && m_cnt == 1) && guard < 40) begin
      tick("seek_d0", 1'b0, 1'b0, 16'h0, 4'h0, m_seg); guard++;
    end
    check("seek_d0_bound", 32'(guard < 40), 32'd1);
    tick("midslot_load", 1'b0, 1'b1, 16'h0005, 4'h0, five);
    tick("midslot_next", 1'b0, 1'b0, 16'h0, 4'h0, m_seg);
    check("midslot_seg", 32'(seg), 32'h12);
    check("midslot_idx", 32'(digit_idx), 32'd0);
    idle("midslot_scan", 16, p);
    check("midslot_pulses", 32'(p), 32'd1);

    // Reset and load together during digit 2: reset wins and the frame restarts.
    tick("pre_load", 1'b0, 1'b1, 16'h1234, 4'h0, vecs[0].segs);
    guard = 0;
    while (m_idx != 2 && guard < 40) begin
      tick("seek_d2", 1'b0, 1'b0, 16'h0, 4'h0, m_seg); guard++;
    end
    check("seek_d2_bound", 32'(guard < 40), 32'd1);
    tick("rst_and_load", 1'b1, 1'b1, 16'h9999, 4'hF, vecs[2].segs);
    idle("post_rst", 15, p);
    check("post_rst_no_fd", 32'(p), 32'd0);
    idle("post_rst_last", 1, p);
    check("post_rst_fd16", 32'(p), 32'd1);
    idle("post_rst_scan", 4, p);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
